// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types for the two-controller Wishbone RAM arbiter.
//   state_e    : arbiter FSM state (IDLE, ISSUE, WAIT_ACK)
//   port_idx_t : controller port index (0 or 1)
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    typedef logic port_idx_t;

    // Port 1 counts as "granted last" out of reset, so port 0 wins the
    // first simultaneous request under round-robin.
    localparam port_idx_t RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/ram_arb_select.sv
// ---------------------------------------------------------------------------
// ram_arb_select
// Combinational grant selection between two requesting controllers.
// Build option RAM_ARB_ROUND_ROBIN_EN:
//   defined   : simultaneous requests go to the port not granted last
//   undefined : fixed priority, port 0 always wins (last_grant unused)
// Ports:
//   req[1:0]    in  : request per controller port
//   last_grant  in  : port granted by the previous transaction
//   grant       out : selected port (valid only when grant_valid)
//   grant_valid out : at least one port is requesting
// ---------------------------------------------------------------------------
module ram_arb_select
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_grant,
    output port_idx_t  grant,
    output logic       grant_valid
);

    assign grant_valid = |req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Contention alternates; a lone requester wins outright.
    assign grant = (req == 2'b11) ? port_idx_t'(~last_grant) : port_idx_t'(req[1]);
`else
    // Port 1 is selected only when port 0 is not asking.
    assign grant = port_idx_t'(~req[0]);

    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Arbitrates two Wishbone B4 pipelined controllers onto one pipelined
// peripheral port, one transaction outstanding at a time.
// Build option RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed
// priority (see ram_arb_select).
// Ports:
//   wb_clock_i, wb_reset_ni       : clock, async active-low reset
//   mN_addr_i/data_i/we_i         : controller N request (N = 0, 1)
//   mN_cycle_i/strobe_i           : controller N CYC/STB
//   mN_data_o/ack_o/stall_o       : controller N response
//   wbp_addr_o/data_o/we_o        : peripheral request
//   wbp_cycle_o/strobe_o          : peripheral CYC/STB
//   wbp_data_i/stall_i/ack_i      : peripheral response
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_ni,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic                  m0_we_i,
    input  logic                  m0_cycle_i,
    input  logic                  m0_strobe_i,
    output logic                  m0_stall_o,
    output logic                  m0_ack_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    input  logic                  m1_we_i,
    input  logic                  m1_cycle_i,
    input  logic                  m1_strobe_i,
    output logic                  m1_stall_o,
    output logic                  m1_ack_o,
    output logic [ADDR_WIDTH-1:0] wbp_addr_o,
    output logic [DATA_WIDTH-1:0] wbp_data_o,
    input  logic [DATA_WIDTH-1:0] wbp_data_i,
    output logic                  wbp_we_o,
    output logic                  wbp_cycle_o,
    output logic                  wbp_strobe_o,
    input  logic                  wbp_stall_i,
    input  logic                  wbp_ack_i
);

    state_e                state_q, state_d;
    port_idx_t             grant_q, grant_d;     // owner of the current transaction
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  aborted_q, aborted_d; // owner dropped CYC mid-transaction
    logic [1:0]            ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0] req;
    port_idx_t  last_grant;
    port_idx_t  sel_grant;
    logic       sel_valid;
    logic       grant_ok;
    logic       owner_cyc;

    assign req = {m1_cycle_i & m1_strobe_i, m0_cycle_i & m0_strobe_i};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // The transaction owner register doubles as the last-grant history.
    assign last_grant = grant_q;
`else
    assign last_grant = RESET_LAST_GRANT;
`endif

    ram_arb_select u_select (
        .req         (req),
        .last_grant  (last_grant),
        .grant       (sel_grant),
        .grant_valid (sel_valid)
    );

    // No grant while an ack is being returned: the next acceptance is the
    // cycle after the ack pulse.
    assign grant_ok  = (state_q == IDLE) && sel_valid && (ack_q == 2'b00);
    assign owner_cyc = grant_q ? m1_cycle_i : m0_cycle_i;

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can leave
        // a signal unassigned and infer a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        aborted_d = aborted_q;
        ack_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    grant_d   = sel_grant;
                    addr_d    = sel_grant ? m1_addr_i : m0_addr_i;
                    wdata_d   = sel_grant ? m1_data_i : m0_data_i;
                    we_d      = sel_grant ? m1_we_i   : m0_we_i;
                    aborted_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!owner_cyc) aborted_d = 1'b1;
                if (!wbp_stall_i) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!owner_cyc) aborted_d = 1'b1;
                if (wbp_ack_i) begin
                    state_d = IDLE;
                    // An abandoned transaction completes silently on the
                    // controller side: no ack and no data update.
                    if (!aborted_q && owner_cyc) begin
                        if (grant_q) begin
                            ack_d[1] = 1'b1;
                            rdata1_d = wbp_data_i;
                        end else begin
                            ack_d[0] = 1'b1;
                            rdata0_d = wbp_data_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state_q   <= IDLE;
            grant_q   <= RESET_LAST_GRANT;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            aborted_q <= 1'b0;
            ack_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            aborted_q <= aborted_d;
            ack_q     <= ack_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Bus controls decode straight from state so reset drops CYC at once.
    assign wbp_cycle_o  = (state_q != IDLE);
    assign wbp_strobe_o = (state_q == ISSUE);
    assign wbp_addr_o   = addr_q;
    assign wbp_data_o   = wdata_q;
    assign wbp_we_o     = we_q;

    assign m0_stall_o = ~(grant_ok && (sel_grant == 1'b0));
    assign m1_stall_o = ~(grant_ok && (sel_grant == 1'b1));
    assign m0_ack_o   = ack_q[0];
    assign m1_ack_o   = ack_q[1];
    assign m0_data_o  = rdata0_q;
    assign m1_data_o  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter: directed scenarios followed by
// randomized single and contending transactions, compared against a
// transaction-level model (per-port last read data, last-grant history).
// Honours RAM_ARB_ROUND_ROBIN_EN for the expected arbitration outcome.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [16:0] m_addr  [2];
    logic [7:0]  m_wdata [2];
    wire  [7:0]  m0_rdata, m1_rdata;
    wire  [1:0]  m_stall, m_ack;
    wire  [16:0] wbp_addr;
    wire  [7:0]  wbp_wdata;
    logic [7:0]  wbp_rdata;
    wire         wbp_we, wbp_cyc, wbp_stb;
    logic        wbp_stall, wbp_ack;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] mdl_data [2];
    int         mdl_last;

    ram_arbiter dut (
        .wb_clock_i   (clk),
        .wb_reset_ni  (rst_n),
        .m0_addr_i    (m_addr[0]),
        .m0_data_i    (m_wdata[0]),
        .m0_data_o    (m0_rdata),
        .m0_we_i      (m_we[0]),
        .m0_cycle_i   (m_cyc[0]),
        .m0_strobe_i  (m_stb[0]),
        .m0_stall_o   (m_stall[0]),
        .m0_ack_o     (m_ack[0]),
        .m1_addr_i    (m_addr[1]),
        .m1_data_i    (m_wdata[1]),
        .m1_data_o    (m1_rdata),
        .m1_we_i      (m_we[1]),
        .m1_cycle_i   (m_cyc[1]),
        .m1_strobe_i  (m_stb[1]),
        .m1_stall_o   (m_stall[1]),
        .m1_ack_o     (m_ack[1]),
        .wbp_addr_o   (wbp_addr),
        .wbp_data_o   (wbp_wdata),
        .wbp_data_i   (wbp_rdata),
        .wbp_we_o     (wbp_we),
        .wbp_cycle_o  (wbp_cyc),
        .wbp_strobe_o (wbp_stb),
        .wbp_stall_i  (wbp_stall),
        .wbp_ack_i    (wbp_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model arbitration: which port the spec says wins among requesters.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            return (mdl_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    task automatic set_req(input int p, input logic we, input logic [16:0] a, input logic [7:0] d);
        m_cyc[p]   = 1'b1;
        m_stb[p]   = 1'b1;
        m_we[p]    = we;
        m_addr[p]  = a;
        m_wdata[p] = d;
    endtask

    task automatic check_rdata(input string tag);
        check({tag, "_rdata0"}, m0_rdata, mdl_data[0]);
        check({tag, "_rdata1"}, m1_rdata, mdl_data[1]);
    endtask

    // Runs one transaction for port p, whose request is already asserted and
    // which must win in the current cycle. Returns in the cycle after the
    // controller ack slot.
    task automatic serve(input int p, input logic [7:0] rd, input int stall_n,
                         input int ack_dly, input bit drop);
        logic [16:0] ea;
        logic [7:0]  ed;
        logic        ew;
        ea = m_addr[p];
        ed = m_wdata[p];
        ew = m_we[p];
        wbp_stall = (stall_n > 0);
        #1;
        check("grant_stall", m_stall[p], 1'b0);
        check("other_stall", m_stall[1-p], 1'b1);
        tick();
        // Accepted: drop STB and scramble request lines to prove they were registered.
        m_stb[p]   = 1'b0;
        m_addr[p]  = 17'($urandom);
        m_wdata[p] = 8'($urandom);
        m_we[p]    = 1'($urandom);
        mdl_last   = p;
        check("issue_stb", wbp_stb, 1'b1);
        check("issue_cyc", wbp_cyc, 1'b1);
        check("issue_addr", wbp_addr, ea);
        check("issue_we", wbp_we, ew);
        if (ew) check("issue_wdata", wbp_wdata, ed);
        for (int i = 0; i < stall_n; i++) begin
            wbp_ack = 1'($urandom);  // acks while still issuing must be ignored
            tick();
            check("stall_stb", wbp_stb, 1'b1);
            check("stall_addr", wbp_addr, ea);
            if (i == stall_n - 1) wbp_stall = 1'b0;
        end
        wbp_ack = 1'($urandom);
        tick();
        wbp_ack = 1'b0;
        check("wait_stb", wbp_stb, 1'b0);
        check("wait_cyc", wbp_cyc, 1'b1);
        if (drop) m_cyc[p] = 1'b0;
        for (int d = 1; d < ack_dly; d++) begin
            tick();
            check("wait_hold_cyc", wbp_cyc, 1'b1);
            check("wait_no_ack", m_ack, 2'b00);
        end
        wbp_ack   = 1'b1;
        wbp_rdata = rd;
        tick();
        wbp_ack   = 1'b0;
        wbp_rdata = 8'($urandom);
        if (!drop) mdl_data[p] = rd;
        check("ack0", m_ack[0], (!drop && p == 0));
        check("ack1", m_ack[1], (!drop && p == 1));
        check_rdata("done");
        check("done_cyc", wbp_cyc, 1'b0);
        if (!drop) check("ack_slot_stall", m_stall, 2'b11);
        m_cyc[p] = 1'b0;
        m_stb[p] = 1'b0;
        tick();
        check("ack_pulse", m_ack, 2'b00);
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        m_cyc     = '0;
        m_stb     = '0;
        m_we      = '0;
        m_addr[0] = '0;
        m_addr[1] = '0;
        m_wdata[0] = '0;
        m_wdata[1] = '0;
        wbp_rdata = '0;
        wbp_stall = 1'b0;
        wbp_ack   = 1'b0;
        mdl_data[0] = '0;
        mdl_data[1] = '0;
        mdl_last    = 1;

        // Reset values
        #2;
        check("rst_cyc", wbp_cyc, 1'b0);
        check("rst_stb", wbp_stb, 1'b0);
        check("rst_we", wbp_we, 1'b0);
        check("rst_addr", wbp_addr, 17'h0);
        check("rst_wdata", wbp_wdata, 8'h0);
        check("rst_ack", m_ack, 2'b00);
        check("rst_stall", m_stall, 2'b11);
        check_rdata("rst");

        // Both ports read together; release reset just before the first edge.
        set_req(0, 1'b0, 17'h00100, 8'h00);
        set_req(1, 1'b0, 17'h00200, 8'h00);
        #1 rst_n = 1'b1;
        w = pick(1'b1, 1'b1);
        serve(w, 8'h11, 0, 1, 1'b0);
`ifndef RAM_ARB_ROUND_ROBIN_EN
        // Port 0 asks again while port 1 still waits: port 0 wins again.
        set_req(0, 1'b0, 17'h00104, 8'h00);
        serve(pick(1'b1, 1'b1), 8'h22, 0, 2, 1'b0);
`endif
        serve(pick(m_cyc[0] & m_stb[0], m_cyc[1] & m_stb[1]), 8'h33, 0, 1, 1'b0);

        // Port 0 write of 0x5A to 0x1F000, peripheral acks 6 cycles after STB.
        set_req(0, 1'b1, 17'h1F000, 8'h5A);
        serve(0, 8'h44, 0, 6, 1'b0);

        // Peripheral stalls three cycles in ISSUE.
        set_req(1, 1'b0, 17'h0ABCD, 8'h00);
        serve(1, 8'h55, 3, 2, 1'b0);

        // Port 1 abandons a read of 0x00010 during WAIT_ACK.
        set_req(1, 1'b0, 17'h00010, 8'h00);
        serve(1, 8'hC3, 0, 3, 1'b1);

        // Spurious peripheral ack while idle.
        wbp_ack = 1'b1;
        tick();
        wbp_ack = 1'b0;
        check("spur_ack", m_ack, 2'b00);
        check("spur_cyc", wbp_cyc, 1'b0);
        check_rdata("spur");
        set_req(0, 1'b0, 17'h00777, 8'h00);
        serve(0, 8'h66, 1, 1, 1'b0);

        // Reset pulsed in WAIT_ACK.
        set_req(0, 1'b0, 17'h00ABC, 8'h00);
        wbp_stall = 1'b0;
        #1;
        tick();
        m_stb[0] = 1'b0;
        tick();
        check("prerst_cyc", wbp_cyc, 1'b1);
        check("prerst_stb", wbp_stb, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cyc", wbp_cyc, 1'b0);
        check("midrst_stall", m_stall, 2'b11);
        check("midrst_ack", m_ack, 2'b00);
        mdl_data[0] = '0;
        mdl_data[1] = '0;
        mdl_last    = 1;
        check_rdata("midrst");
        m_cyc[0] = 1'b0;
        #1 rst_n = 1'b1;
        wbp_ack  = 1'b1;   // the stale peripheral ack arrives after reset
        tick();
        wbp_ack  = 1'b0;
        check("postrst_ack", m_ack, 2'b00);
        tick();
        check("postrst_ack2", m_ack, 2'b00);
        check("postrst_cyc", wbp_cyc, 1'b0);
        set_req(1, 1'b1, 17'h13579, 8'hA5);
        serve(1, 8'h77, 0, 2, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_req(0, 1'($urandom), 17'($urandom), 8'($urandom));
                set_req(1, 1'($urandom), 17'($urandom), 8'($urandom));
                w = pick(1'b1, 1'b1);
                serve(w, 8'($urandom), $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
                serve(pick(m_cyc[0] & m_stb[0], m_cyc[1] & m_stb[1]), 8'($urandom),
                      $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
            end else begin
                w = $urandom_range(0, 1);
                set_req(w, 1'($urandom), 17'($urandom), 8'($urandom));
                serve(w, 8'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                      ($urandom_range(0, 5) == 0));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
